// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Optional parity support is selected with the UART_TX_PARITY_EN macro.
package uart_pkg;

    localparam int DATA_BITS_BASE = 5;
    localparam int DATA_MAX       = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // 2-bit data length code: 00=5 ... 11=8 bits
    typedef enum logic [1:0] {
        DB5,
        DB6,
        DB7,
        DB8
    } data_bits_e;

    function automatic logic [3:0] num_bits(data_bits_e code);
        return {2'b00, code} + 4'(DATA_BITS_BASE);
    endfunction

    // Even parity over only the configured number of data bits
    function automatic logic even_par(logic [DATA_MAX-1:0] d,
                                      data_bits_e code);
        logic [DATA_MAX-1:0] mask;
        mask = 8'hFF >> (2'd3 - code);
        return ^(d & mask);
    endfunction

endpackage

// File: rtl/uart_tx_controller_if.sv
// Byte handshake between host TX holding logic and the frame sequencer.
// Master drives data/valid, slave answers with ready.
import uart_pkg::*;

interface uart_tx_controller_if;

    logic [DATA_MAX-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period divisor: counts 0..div_i, pulses bit_end_o on the last clock.
// restart_i forces the count back to 0 so a new phase gets a full period.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_i,
    input  logic             restart_i,
    output logic             bit_end_o
);

    logic [DIV_W-1:0] cnt_q;

    assign bit_end_o = (cnt_q == div_i);

    // Free-running period counter with restart and wrap at bit end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart_i || bit_end_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit frame sequencer: START, DATA, optional PARITY, STOP.
// Define UART_TX_PARITY_EN to build the PARITY phase; otherwise it is absent.
import uart_pkg::*;

module uart_tx_controller #(
    parameter int DIV_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic [1:0]        data_bits_i,
    input  logic              stop2_i,
    input  logic              parity_en_i,
    input  logic              parity_odd_i,
    uart_tx_controller_if.slave tx_if,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        bit_cnt_o
);

    tx_state_e           state_q;
    logic                tx_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic [3:0]          cnt_q;
    logic [3:0]          nbit_q;
    logic [DATA_MAX-1:0] shift_q;
    logic                stop2_q;
    logic                stop_sec_q;
    logic [DIV_W-1:0]    div_q;
    logic                accept;
    logic                bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_q;
`else
    logic unused_par;
    assign unused_par = parity_en_i ^ parity_odd_i;
`endif

    assign accept       = tx_if.tx_valid && ready_q;
    assign tx_if.tx_ready = ready_q;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign bit_cnt_o    = cnt_q;

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_i     (div_q),
        .restart_i (accept),
        .bit_end_o (bit_end)
    );

    // Frame FSM with registered line, status and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            nbit_q     <= '0;
            shift_q    <= '0;
            stop2_q    <= 1'b0;
            stop_sec_q <= 1'b0;
            div_q      <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= START;
                        tx_q       <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        nbit_q     <= num_bits(data_bits_e'(data_bits_i));
                        shift_q    <= tx_if.tx_data;
                        stop2_q    <= stop2_i;
                        stop_sec_q <= 1'b0;
                        div_q      <= baud_div_i;
`ifdef UART_TX_PARITY_EN
                        par_en_q   <= parity_en_i;
                        par_q      <= even_par(tx_if.tx_data,
                                               data_bits_e'(data_bits_i))
                                      ^ parity_odd_i;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q   <= cnt_q + 4'd1;
                        shift_q <= shift_q >> 1;
                        if (cnt_q + 4'd1 == nbit_q) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state_q <= PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (stop2_q && !stop_sec_q) begin
                            stop_sec_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller: frame bit patterns, timing,
// back-to-back handshake, async reset abort and mid-frame config changes.
module tb_uart_tx_controller;

    logic        clk;
    logic        rst_n;
    logic [15:0] baud_div_i;
    logic [1:0]  data_bits_i;
    logic        stop2_i;
    logic        parity_en_i;
    logic        parity_odd_i;
    logic        tx_o;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  bit_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_controller_if u_if ();

    uart_tx_controller #(
        .DIV_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_div_i   (baud_div_i),
        .data_bits_i  (data_bits_i),
        .stop2_i      (stop2_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .tx_if        (u_if),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bit_cnt_o    (bit_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Send one frame starting at a negedge and check every clock of it.
    // exp: line value per bit period, bit 0 = START.
    task automatic send(input logic [7:0] d, input logic [1:0] db,
                        input logic s2, input logic pe, input logic po,
                        input logic [15:0] dv, input logic [15:0] exp,
                        input int nb, input int nd, input bit hold,
                        input bit scr, input logic [15:0] sdv,
                        input logic [1:0] sdb);
        int p;
        int ec;
        p = int'(dv) + 1;
        u_if.tx_data  = d;
        data_bits_i   = db;
        stop2_i       = s2;
        parity_en_i   = pe;
        parity_odd_i  = po;
        baud_div_i    = dv;
        u_if.tx_valid = 1'b1;
        chk("ready_pre", u_if.tx_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) u_if.tx_valid = 1'b0;
        if (scr) begin
            baud_div_i   = sdv;
            data_bits_i  = sdb;
            u_if.tx_data = ~d;
            stop2_i      = ~s2;
        end
        for (int b = 0; b < nb; b++) begin
            ec = (b == 0) ? 0 : ((b <= nd) ? b - 1 : nd);
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                chk("line", tx_o, exp[b]);
                chk("busy", busy_o, 1);
                chk("ready_busy", u_if.tx_ready, 0);
                chk("done_early", done_o, 0);
                chk("bit_cnt", bit_cnt_o, ec);
            end
        end
        @(negedge clk);
        chk("done", done_o, 1);
        chk("ready_end", u_if.tx_ready, 1);
        chk("busy_end", busy_o, 0);
        chk("cnt_end", bit_cnt_o, 0);
        chk("line_idle", tx_o, 1);
        u_if.tx_valid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        baud_div_i    = 16'd3;
        data_bits_i   = 2'b11;
        stop2_i       = 1'b0;
        parity_en_i   = 1'b0;
        parity_odd_i  = 1'b0;
        u_if.tx_data  = 8'h00;
        u_if.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_o, 1);
        chk("rst_ready", u_if.tx_ready, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", bit_cnt_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 0x55, 4 clocks per bit
        send(8'h55, 2'b11, 0, 0, 0, 16'd3, 16'b1010101010,
             10, 8, 0, 0, 16'd0, 2'b00);
        @(negedge clk);

        // 5 data bits of 0xFF, two stop bits, one clock per bit
        send(8'hFF, 2'b00, 1, 0, 0, 16'd0, 16'b11111110,
             8, 5, 0, 0, 16'd0, 2'b00);
        @(negedge clk);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 2'b11, 0, 1, 0, 16'd1, 16'b11000001110,
             11, 8, 0, 0, 16'd0, 2'b00);
        @(negedge clk);
        send(8'h07, 2'b11, 0, 1, 1, 16'd1, 16'b10000001110,
             11, 8, 0, 0, 16'd0, 2'b00);
        @(negedge clk);
        send(8'h80, 2'b10, 0, 1, 0, 16'd1, 16'b1000000000,
             10, 7, 0, 0, 16'd0, 2'b00);
        @(negedge clk);
`else
        // parity request ignored when the feature is not built
        send(8'h07, 2'b11, 0, 1, 0, 16'd1, 16'b1000001110,
             10, 8, 0, 0, 16'd0, 2'b00);
        @(negedge clk);
`endif

        // back-to-back with valid held high
        send(8'hA5, 2'b11, 0, 0, 0, 16'd1, 16'b1101001010,
             10, 8, 1, 0, 16'd0, 2'b00);
        send(8'h3C, 2'b11, 0, 0, 0, 16'd1, 16'b1001111000,
             10, 8, 1, 0, 16'd0, 2'b00);
        @(negedge clk);

        // config changed mid-frame, next frame uses the new config
        send(8'h0F, 2'b11, 0, 0, 0, 16'd1, 16'b1000011110,
             10, 8, 0, 1, 16'd0, 2'b00);
        send(8'h0A, 2'b00, 0, 0, 0, 16'd0, 16'b1010100,
             7, 5, 0, 0, 16'd0, 2'b00);
        @(negedge clk);

        // async reset in the middle of DATA
        u_if.tx_data  = 8'h00;
        data_bits_i   = 2'b11;
        stop2_i       = 1'b0;
        parity_en_i   = 1'b0;
        baud_div_i    = 16'd3;
        u_if.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        u_if.tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_line", tx_o, 0);
        chk("pre_rst_busy", busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_tx", tx_o, 1);
        chk("abort_busy", busy_o, 0);
        chk("abort_ready", u_if.tx_ready, 1);
        chk("abort_cnt", bit_cnt_o, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_done", done_o, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_done", done_o, 0);
            chk("post_tx", tx_o, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
